tetris_raster: RTL and testbench

- Raster-side initiator for the playfield cell lookup; the other end of the tetris cell-colour interface.
- Tracks the active-video position from the HDMI timing stream and converts screen pixels into playfield cell coordinates o_cell_x/o_cell_y.
- Takes the returned cell colour (1-cycle registered lookup) and composites playfield, border and background into a pipelined output pixel aligned with a delayed data-enable.
- Sits between the HDMI timing generator/encoder and the tetris playfield store.

---
 rtl/tetris_raster.sv | 216 +++++++++++++++++++++
 tb/tb_tetris_raster.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_raster.sv
// tetris_raster
//
// Raster-side initiator for the playfield cell lookup. Follows the active
// video position from the HDMI timing stream, converts the current screen
// pixel into a playfield cell coordinate (cell_x, cell_y), and composites the
// returned cell colour with the border and background into the output pixel.
//
// Ports:
//   i_pixclk      pixel clock, sole clock
//   i_reset_n     synchronous active-low reset
//   i_de          active-video enable from the timing generator
//   i_newframe    one-cycle pulse in vertical blanking before the first line
//   o_cell_x      playfield column presented to the lookup (0..9)
//   o_cell_y      playfield row presented to the lookup (0..TETRIS_ROWS-1)
//   i_cell_pixel  cell colour, registered by the lookup one edge after
//                 o_cell_x/o_cell_y
//   o_de          i_de delayed so that it lines up with o_pixel
//   o_pixel       composited pixel
//
// Timing: i_de sampled at edge t produces o_cell_x/o_cell_y at edge t, the
// lookup captures that request at t+1, and o_de/o_pixel update at t+2.
//
// Interface handshake: there is no back-pressure. The lookup must return the
// colour for the coordinate presented after edge t as i_cell_pixel after
// edge t+1; i_de is a plain per-cycle qualifier, no valid/ready pair exists.
//
// o_cell_y is 4 bits wide for the default 16 rows and widens automatically
// when more rows are configured so that every row stays addressable.

module tetris_raster #(
  parameter int TETRIS_ROWS = 16,
  parameter int BPP         = 24,
  parameter int X0          = 200,
  parameter int Y0          = 40,
  parameter int CELL        = 24,
  parameter int BORDER      = 4,
  parameter logic [BPP-1:0] BORDER_COLOR = 24'h808080,
  parameter logic [BPP-1:0] BG_COLOR     = 24'h000000,
  localparam int CY_W = (TETRIS_ROWS > 16) ? $clog2(TETRIS_ROWS) : 4
) (
  input  logic            i_pixclk,
  input  logic            i_reset_n,
  input  logic            i_de,
  input  logic            i_newframe,
  output logic [3:0]      o_cell_x,
  output logic [CY_W-1:0] o_cell_y,
  input  logic [BPP-1:0]  i_cell_pixel,
  output logic            o_de,
  output logic [BPP-1:0]  o_pixel
);

  localparam int SUB_W = $clog2(CELL);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL - 1);

  // Geometry bounds, 32 bits wide so that anything past the 12-bit counter
  // range simply never matches. Border low edges clip at 0.
  localparam logic [31:0] IX_LO = 32'(X0);
  localparam logic [31:0] IX_HI = 32'(X0 + 10 * CELL);
  localparam logic [31:0] IY_LO = 32'(Y0);
  localparam logic [31:0] IY_HI = 32'(Y0 + TETRIS_ROWS * CELL);
  localparam logic [31:0] BX_LO = (X0 >= BORDER) ? 32'(X0 - BORDER) : 32'd0;
  localparam logic [31:0] BX_HI = 32'(X0 + 10 * CELL + BORDER);
  localparam logic [31:0] BY_LO = (Y0 >= BORDER) ? 32'(Y0 - BORDER) : 32'd0;
  localparam logic [31:0] BY_HI = 32'(Y0 + TETRIS_ROWS * CELL + BORDER);

  typedef enum logic [1:0] {
    RG_BG       = 2'd0,
    RG_BORDER   = 2'd1,
    RG_INTERIOR = 2'd2
  } region_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Counter registers. px_r holds the position of the next pixel of the line,
  // py_r the current line number.
  logic [11:0]     px_r, py_r;
  logic [SUB_W-1:0] sub_x_r, sub_y_r;
  logic [3:0]      cell_x_r;
  logic [CY_W-1:0] cell_y_r;
  logic            synced;

  // Pipeline registers. de1 doubles as the registered copy of i_de used for
  // edge detection.
  logic            de1, de2;
  region_t         region1, region2;

  // Current-cycle position.
  logic [11:0]     px_cur, py_cur;
  logic [31:0]     px32, py32;
  logic            rise, fall;
  logic            in_x, in_y, in_bx, in_by;
  logic [SUB_W-1:0] sx_cur;
  logic [3:0]      cx_cur;
  logic [CY_W-1:0] cy_cur;
  logic [11:0]     py_nxt;
  region_t         region_cur;

  always_comb begin
    rise   = i_de & ~de1;
    fall   = ~i_de & de1;
    px_cur = rise ? 12'd0 : px_r;
    // A newframe pulse during active video turns the rest of the line into
    // line 0 immediately.
    py_cur = i_newframe ? 12'd0 : py_r;
    px32   = {20'd0, px_cur};
    py32   = {20'd0, py_cur};
    py_nxt = sat_inc(py_r);

    in_x  = (px32 >= IX_LO) && (px32 < IX_HI);
    in_y  = (py32 >= IY_LO) && (py32 < IY_HI);
    in_bx = (px32 >= BX_LO) && (px32 < BX_HI);
    in_by = (py32 >= BY_LO) && (py32 < BY_HI);

    // The first interior column restarts the horizontal sub-cell tracking.
    sx_cur = (px32 == IX_LO) ? '0 : sub_x_r;
    cx_cur = (px32 == IX_LO) ? 4'd0 : cell_x_r;
    cy_cur = i_newframe ? '0 : cell_y_r;

    region_cur = RG_BG;
    if (in_x && in_y)
      region_cur = RG_INTERIOR;
    else if (in_bx && in_by)
      region_cur = RG_BORDER;
  end

  // Position counters and sub-cell tracking.
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      px_r     <= '0;
      py_r     <= '0;
      sub_x_r  <= '0;
      cell_x_r <= '0;
      sub_y_r  <= '0;
      cell_y_r <= '0;
      synced   <= 1'b0;
    end else begin
      if (i_newframe)
        synced <= 1'b1;

      if (i_de) begin
        px_r <= sat_inc(px_cur);
        if (in_x) begin
          if (sx_cur == SUB_LAST) begin
            sub_x_r  <= '0;
            cell_x_r <= cx_cur + 4'd1;
          end else begin
            sub_x_r  <= sx_cur + SUB_W'(1);
            cell_x_r <= cx_cur;
          end
        end
      end

      if (i_newframe) begin
        py_r     <= '0;
        sub_y_r  <= '0;
        cell_y_r <= '0;
      end else if (fall) begin
        py_r <= py_nxt;
        if ({20'd0, py_nxt} == IY_LO) begin
          sub_y_r  <= '0;
          cell_y_r <= '0;
        end else if (in_y) begin
          if (sub_y_r == SUB_LAST) begin
            sub_y_r  <= '0;
            cell_y_r <= cell_y_r + CY_W'(1);
          end else begin
            sub_y_r <= sub_y_r + SUB_W'(1);
          end
        end
      end
    end
  end

  // Lookup request, region and data-enable pipeline, output compositing.
  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      o_cell_x <= '0;
      o_cell_y <= '0;
      region1  <= RG_BG;
      region2  <= RG_BG;
      de1      <= 1'b0;
      de2      <= 1'b0;
      o_de     <= 1'b0;
      o_pixel  <= '0;
    end else begin
      // Only interior pixels produce a non-zero request, so the lookup never
      // sees a coordinate outside the playfield.
      if (i_de && in_x && in_y) begin
        o_cell_x <= cx_cur;
        o_cell_y <= cy_cur;
      end else begin
        o_cell_x <= '0;
        o_cell_y <= '0;
      end
      region1 <= region_cur;
      de1     <= i_de;

      region2 <= region1;
      de2     <= de1;

      o_de <= de2;
      if (!de2 || !synced) begin
        o_pixel <= '0;
      end else begin
        case (region2)
          RG_INTERIOR: o_pixel <= i_cell_pixel;
          RG_BORDER:   o_pixel <= BORDER_COLOR;
          default:     o_pixel <= BG_COLOR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tetris_raster.sv
// Bench for tetris_raster: two instances run side by side, one with the
// default geometry and one with a 20-row, 16-pixel-cell playfield at X0=0.
// Each drives directed lines and compares against hand-computed points.

module tb_tetris_raster;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance 1: default geometry ----------------
  logic        rst1_n, de_in1, nf1, de_out1;
  logic [3:0]  cx1;
  logic [3:0]  cy1;
  logic [23:0] cpix1, pix1;

  tetris_raster dut1 (
    .i_pixclk     (clk),
    .i_reset_n    (rst1_n),
    .i_de         (de_in1),
    .i_newframe   (nf1),
    .o_cell_x     (cx1),
    .o_cell_y     (cy1),
    .i_cell_pixel (cpix1),
    .o_de         (de_out1),
    .o_pixel      (pix1)
  );

  // ---------------- instance 2: 20 rows, 16 px cells, X0=0, Y0=4 ----------------
  logic        rst2_n, de_in2, nf2, de_out2;
  logic [3:0]  cx2;
  logic [4:0]  cy2;
  logic [23:0] cpix2, pix2;

  tetris_raster #(
    .TETRIS_ROWS (20),
    .CELL        (16),
    .X0          (0),
    .Y0          (4),
    .BORDER      (4)
  ) dut2 (
    .i_pixclk     (clk),
    .i_reset_n    (rst2_n),
    .i_de         (de_in2),
    .i_newframe   (nf2),
    .o_cell_x     (cx2),
    .o_cell_y     (cy2),
    .i_cell_pixel (cpix2),
    .o_de         (de_out2),
    .o_pixel      (pix2)
  );

  // Lookup models: one registered edge, colour encodes the coordinate.
  always_ff @(posedge clk) begin
    cpix1 <= {cx1, cy1, 16'h0000};
    cpix2 <= {cx2, cy2, 15'h0000};
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          line;
    int          px;
    logic [3:0]  cx;
    logic [4:0]  cy;
    logic [23:0] pix;
  } cp_t;

  cp_t tab1[$];
  cp_t tab2[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // History of the two previous samples per instance: [0] = k-1, [1] = k-2.
  int   hl1[2], hp1[2], hl2[2], hp2[2];
  logic hd1[2], hd2[2];

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick1(input logic de, input logic nf, input logic rst,
                       input int line, input int px, input logic zero);
    @(negedge clk);
    de_in1 = de; nf1 = nf; rst1_n = rst;
    @(posedge clk);
    #1;
    if (!rst) begin
      hd1[0] = 1'b0; hd1[1] = 1'b0;
      hl1[0] = -1; hl1[1] = -1;
    end
    check("d1_cx_range", {23'd0, (cx1 <= 4'd9)}, 24'd1);
    check("d1_de", {23'd0, de_out1}, {23'd0, hd1[1]});
    if (!hd1[1] || zero)
      check("d1_pix_zero", pix1, 24'h0);
    foreach (tab1[i]) begin
      if (rst && de && line == tab1[i].line && px == tab1[i].px) begin
        check($sformatf("d1_cx L%0d P%0d", line, px), {20'd0, cx1}, {20'd0, tab1[i].cx});
        check($sformatf("d1_cy L%0d P%0d", line, px), {20'd0, cy1}, {19'd0, tab1[i].cy});
      end
      if (hd1[1] && hl1[1] == tab1[i].line && hp1[1] == tab1[i].px)
        check($sformatf("d1_pix L%0d P%0d", hl1[1], hp1[1]), pix1, tab1[i].pix);
    end
    hl1[1] = hl1[0]; hp1[1] = hp1[0]; hd1[1] = hd1[0];
    hl1[0] = rst ? line : -1;
    hp1[0] = px;
    hd1[0] = rst ? de : 1'b0;
  endtask

  task automatic tick2(input logic de, input logic nf, input logic rst,
                       input int line, input int px, input logic zero);
    @(negedge clk);
    de_in2 = de; nf2 = nf; rst2_n = rst;
    @(posedge clk);
    #1;
    if (!rst) begin
      hd2[0] = 1'b0; hd2[1] = 1'b0;
      hl2[0] = -1; hl2[1] = -1;
    end
    check("d2_cell_range", {23'd0, (cx2 <= 4'd9 && cy2 <= 5'd19)}, 24'd1);
    check("d2_de", {23'd0, de_out2}, {23'd0, hd2[1]});
    if (!hd2[1] || zero)
      check("d2_pix_zero", pix2, 24'h0);
    foreach (tab2[i]) begin
      if (rst && de && line == tab2[i].line && px == tab2[i].px) begin
        check($sformatf("d2_cx L%0d P%0d", line, px), {20'd0, cx2}, {20'd0, tab2[i].cx});
        check($sformatf("d2_cy L%0d P%0d", line, px), {19'd0, cy2}, {19'd0, tab2[i].cy});
      end
      if (hd2[1] && hl2[1] == tab2[i].line && hp2[1] == tab2[i].px)
        check($sformatf("d2_pix L%0d P%0d", hl2[1], hp2[1]), pix2, tab2[i].pix);
    end
    hl2[1] = hl2[0]; hp2[1] = hp2[0]; hd2[1] = hd2[0];
    hl2[0] = rst ? line : -1;
    hp2[0] = px;
    hd2[0] = rst ? de : 1'b0;
  endtask

  // 640 active pixels, short blanking to keep the run compact.
  task automatic line1(input int line, input logic zero);
    for (int p = 0; p < 640; p++) tick1(1'b1, 1'b0, 1'b1, line, p, zero);
    for (int b = 0; b < 8; b++)   tick1(1'b0, 1'b0, 1'b1, -1, -1, zero);
  endtask

  // 168 active pixels (interior 0..159, right border 160..163, then bg).
  task automatic line2(input int line, input logic zero);
    for (int p = 0; p < 168; p++) tick2(1'b1, 1'b0, 1'b1, line, p, zero);
    for (int b = 0; b < 2; b++)   tick2(1'b0, 1'b0, 1'b1, -1, -1, zero);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst1_n = 1'b0; de_in1 = 1'b0; nf1 = 1'b0;
    rst2_n = 1'b0; de_in2 = 1'b0; nf2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hl1[i] = -1; hp1[i] = -1; hd1[i] = 1'b0;
      hl2[i] = -1; hp2[i] = -1; hd2[i] = 1'b0;
    end

    // Default geometry: interior x 200..439, y 40..423; border 196..443 / 36..427.
    tab1.push_back('{35, 300, 4'd0, 5'd0, 24'h000000});
    tab1.push_back('{36, 196, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{36, 300, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{39, 443, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{40, 195, 4'd0, 5'd0, 24'h000000});
    tab1.push_back('{40, 196, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{40, 200, 4'd0, 5'd0, 24'h000000});
    tab1.push_back('{40, 224, 4'd1, 5'd0, 24'h100000});
    tab1.push_back('{40, 439, 4'd9, 5'd0, 24'h900000});
    tab1.push_back('{40, 440, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{40, 443, 4'd0, 5'd0, 24'h808080});
    tab1.push_back('{40, 444, 4'd0, 5'd0, 24'h000000});
    tab1.push_back('{63, 224, 4'd1, 5'd0, 24'h100000});
    tab1.push_back('{64, 195, 4'd0, 5'd0, 24'h000000});
    tab1.push_back('{64, 200, 4'd0, 5'd1, 24'h010000});
    tab1.push_back('{64, 248, 4'd2, 5'd1, 24'h210000});
    tab1.push_back('{64, 439, 4'd9, 5'd1, 24'h910000});

    // Second geometry: interior x 0..159, y 4..323; border to x 163, y 0..327.
    tab2.push_back('{0,   20,  4'd0, 5'd0,  24'h808080});
    tab2.push_back('{3,   16,  4'd0, 5'd0,  24'h808080});
    tab2.push_back('{4,   16,  4'd1, 5'd0,  24'h100000});
    tab2.push_back('{19,  0,   4'd0, 5'd0,  24'h000000});
    tab2.push_back('{20,  0,   4'd0, 5'd1,  24'h008000});
    tab2.push_back('{100, 5,   4'd0, 5'd6,  24'h030000});
    tab2.push_back('{323, 159, 4'd9, 5'd19, 24'h998000});
    tab2.push_back('{323, 160, 4'd0, 5'd0,  24'h808080});
    tab2.push_back('{323, 164, 4'd0, 5'd0,  24'h000000});
    tab2.push_back('{324, 0,   4'd0, 5'd0,  24'h808080});

    fork
      begin
        // Reset and reset-state outputs.
        for (int i = 0; i < 3; i++) tick1(1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
        check("d1_rst_cx", {20'd0, cx1}, 24'd0);
        check("d1_rst_cy", {20'd0, cy1}, 24'd0);
        check("d1_rst_de", {23'd0, de_out1}, 24'd0);
        check("d1_rst_pix", pix1, 24'd0);
        // Not yet synced: o_de follows, o_pixel stays 0.
        for (int p = 0; p < 20; p++) tick1(1'b1, 1'b0, 1'b1, -1, p, 1'b1);
        for (int b = 0; b < 8; b++)  tick1(1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        // Frame A.
        tick1(1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        for (int l = 0; l < 64; l++) line1(l, 1'b0);
        // Line 64 with reset asserted mid-line.
        for (int p = 0; p < 500; p++) tick1(1'b1, 1'b0, 1'b1, 64, p, 1'b0);
        for (int p = 500; p < 502; p++) tick1(1'b1, 1'b0, 1'b0, -1, p, 1'b1);
        for (int p = 502; p < 640; p++) tick1(1'b1, 1'b0, 1'b1, -1, p, 1'b1);
        for (int b = 0; b < 8; b++) tick1(1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        line1(-1, 1'b1);
        line1(-1, 1'b1);
        // Frame B after re-sync.
        tick1(1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
        for (int l = 0; l <= 40; l++) line1(l, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) tick2(1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
        check("d2_rst_cx", {20'd0, cx2}, 24'd0);
        check("d2_rst_cy", {19'd0, cy2}, 24'd0);
        check("d2_rst_de", {23'd0, de_out2}, 24'd0);
        check("d2_rst_pix", pix2, 24'd0);
        // Three unsynced lines move py away from 0.
        for (int l = 0; l < 3; l++) line2(-1, 1'b1);
        // Newframe while i_de is high: rest of this line is line 0.
        for (int p = 0; p < 10; p++) tick2(1'b1, 1'b0, 1'b1, -1, p, 1'b0);
        tick2(1'b1, 1'b1, 1'b1, 0, 10, 1'b0);
        for (int p = 11; p < 168; p++) tick2(1'b1, 1'b0, 1'b1, 0, p, 1'b0);
        for (int b = 0; b < 2; b++) tick2(1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
        for (int l = 1; l <= 324; l++) line2(l, 1'b0);
      end
    join

    // Drain so the last samples reach the outputs.
    for (int i = 0; i < 3; i++) tick1(1'b0, 1'b0, 1'b1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
